// File: rtl/lsu_mem_stage_if.sv
// rtl/lsu_mem_stage_if.sv - data-memory req/ready bus between the LSU and memory
interface lsu_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - RV32I load/store unit: one access per start, stalls the core until done
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  lsu_mem_if.master   mem
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [16:0] TIMEOUT_CNT = 17'(TIMEOUT);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        fault_q;

  logic        illegal, misaligned, dec_fault;
  logic        timeout_hit;
  logic        in_req;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  // Decode looks at the live inputs so a bad access can skip the bus entirely.
  assign illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (is_store && funct3[2]);
  assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign dec_fault  = illegal || misaligned;

  assign timeout_hit = (TIMEOUT != 0) && (({1'b0, cnt} + 17'd1) == TIMEOUT_CNT);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        busy = start;
        if (start) state_nxt = dec_fault ? DONE : REQ;
      end
      REQ: begin
        busy = 1'b1;
        if (mem.mem_ready || timeout_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 16'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE)
        cnt <= 16'd0;
      else if (state == REQ && !mem.mem_ready)
        cnt <= cnt + 16'd1;
    end
  end

  always_comb begin
    byte_sel = addr_q[1] ? (addr_q[0] ? mem.mem_rdata[31:24] : mem.mem_rdata[23:16])
                         : (addr_q[0] ? mem.mem_rdata[15:8]  : mem.mem_rdata[7:0]);
    half_sel = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_val = {24'd0, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = mem.mem_rdata;
    endcase
  end

  // rdata only moves on the edge into DONE, and only for loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      fault_q    <= 1'b0;
      rdata      <= 32'd0;
    end else if (state == IDLE && start) begin
      is_store_q <= is_store;
      funct3_q   <= funct3;
      addr_q     <= addr;
      wdata_q    <= wdata;
      fault_q    <= dec_fault;
      if (dec_fault && !is_store) rdata <= 32'd0;
    end else if (state == REQ) begin
      if (mem.mem_ready) begin
        fault_q <= 1'b0;
        if (!is_store_q) rdata <= load_val;
      end else if (timeout_hit) begin
        fault_q <= 1'b1;
        if (!is_store_q) rdata <= 32'd0;
      end
    end
  end

  assign done  = (state == DONE);
  assign fault = (state == DONE) && fault_q;

  // Bus fields are held at zero outside REQ so the slave never sees stale values.
  assign in_req        = (state == REQ);
  assign mem.mem_req   = in_req;
  assign mem.mem_we    = in_req && is_store_q;
  assign mem.mem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'd0;

  always_comb begin
    mem.mem_be    = 4'b0000;
    mem.mem_wdata = 32'd0;
    if (in_req) begin
      case (funct3_q[1:0])
        2'b00: begin
          mem.mem_be    = 4'b0001 << addr_q[1:0];
          mem.mem_wdata = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          mem.mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
          mem.mem_wdata = {2{wdata_q[15:0]}};
        end
        default: begin
          mem.mem_be    = 4'b1111;
          mem.mem_wdata = wdata_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - self-checking bench for lsu_mem_stage
module tb_lsu_mem_stage;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] rdata;

  lsu_mem_if bus();

  lsu_mem_stage #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .is_store (is_store),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .fault    (fault),
    .rdata    (rdata),
    .mem      (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit          exp_valid;
  string       tag;
  logic        e_busy, e_done, e_fault, e_req, e_we;
  logic [31:0] e_addr, e_wd;
  logic [3:0]  e_be;
  logic [31:0] model_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (st && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    return (int'(a[1:0]) % m_bytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << m_bytes(f3)) - 1) << a[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = m_bytes(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * a[1:0]);
    if (m_bytes(f3) == 1) begin
      s = s & 32'h0000_00FF;
      if (!f3[2] && s[7]) s = s | 32'hFFFF_FF00;
    end else if (m_bytes(f3) == 2) begin
      s = s & 32'h0000_FFFF;
      if (!f3[2] && s[15]) s = s | 32'hFFFF_0000;
    end else begin
      s = w;
    end
    return s;
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      chk({tag, " busy"}, busy, e_busy);
      chk({tag, " done"}, done, e_done);
      chk({tag, " mem_req"}, bus.mem_req, e_req);
      chk({tag, " rdata"}, rdata, model_rdata);
      if (e_req) begin
        chk({tag, " mem_we"}, bus.mem_we, e_we);
        chk({tag, " mem_addr"}, bus.mem_addr, e_addr);
        chk({tag, " mem_be"}, bus.mem_be, e_be);
        chk({tag, " mem_wdata"}, bus.mem_wdata, e_wd);
      end
      if (e_done) chk({tag, " fault"}, fault, e_fault);
    end
  end

  task automatic access(input string nm, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int waits, input logic [31:0] rw);
    int   nreq;
    logic tout;
    tag      = nm;
    start    = 1'b1;
    is_store = st;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = $urandom;
    e_busy = 1'b1; e_done = 1'b0; e_req = 1'b0;
    exp_valid = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    addr     = ~a;
    wdata    = ~wd;
    funct3   = 3'($urandom);
    is_store = ~st;
    if (m_fault(st, f3, a)) begin
      if (!st) model_rdata = 32'd0;
      e_busy = 1'b0; e_done = 1'b1; e_fault = 1'b1; e_req = 1'b0;
    end else begin
      nreq = waits + 1;
      tout = 1'b0;
      if (TO != 0 && nreq > int'(TO)) begin
        nreq = int'(TO);
        tout = 1'b1;
      end
      for (int i = 0; i < nreq; i++) begin
        bus.mem_ready = (i == waits);
        bus.mem_rdata = (i == waits) ? rw : $urandom;
        e_busy = 1'b1; e_done = 1'b0; e_req = 1'b1; e_we = st;
        e_addr = {a[31:2], 2'b00};
        e_be   = m_be(f3, a);
        e_wd   = m_wd(f3, wd);
        @(posedge clk); #1;
      end
      if (!st) model_rdata = tout ? 32'd0 : m_load(f3, a, rw);
      e_busy = 1'b0; e_done = 1'b1; e_fault = tout; e_req = 1'b0;
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = $urandom;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e_busy = 1'b0; e_done = 1'b0; e_req = 1'b0;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    exp_valid = 1'b0; model_rdata = 32'd0; tag = "init";
    e_busy = 0; e_done = 0; e_fault = 0; e_req = 0; e_we = 0;
    e_addr = 0; e_wd = 0; e_be = 0;

    #12;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset fault", fault, 0);
    chk("reset rdata", rdata, 0);
    chk("reset mem_req", bus.mem_req, 0);
    chk("reset mem_we", bus.mem_we, 0);
    chk("reset mem_be", bus.mem_be, 0);
    chk("reset mem_addr", bus.mem_addr, 0);
    chk("reset mem_wdata", bus.mem_wdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;

    access("lw_100", 1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);
    chk("lw_100 rdata literal", rdata, 32'hDEAD_BEEF);
    access("lb_103", 1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h80FF_7F01);
    chk("lb_103 rdata literal", rdata, 32'hFFFF_FF80);
    access("lbu_103", 1'b0, 3'b100, 32'h0000_0103, 32'h0, 1, 32'h80FF_7F01);
    chk("lbu_103 rdata literal", rdata, 32'h0000_0080);
    access("sh_202", 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 3, 32'h0);
    chk("sh_202 rdata unchanged", rdata, 32'h0000_0080);
    access("lh_102", 1'b0, 3'b001, 32'h0000_0102, 32'h0, 2, 32'h80FF_7F01);
    chk("lh_102 rdata literal", rdata, 32'hFFFF_80FF);
    access("lhu_100", 1'b0, 3'b101, 32'h0000_0100, 32'h0, 0, 32'h80FF_7F01);
    chk("lhu_100 rdata literal", rdata, 32'h0000_7F01);
    access("sb_101", 1'b1, 3'b000, 32'h0000_0101, 32'h7766_555A, 1, 32'h0);
    access("sw_104", 1'b1, 3'b010, 32'h0000_0104, 32'hCAFE_0001, 0, 32'h0);
    chk("sw_104 rdata unchanged", rdata, 32'h0000_7F01);
    access("lw_101_mis", 1'b0, 3'b010, 32'h0000_0101, 32'h0, 0, 32'h1111_1111);
    chk("lw_101 rdata literal", rdata, 32'h0);
    access("sbu_ill", 1'b1, 3'b100, 32'h0000_0100, 32'h55, 0, 32'h0);
    access("lh_103_mis", 1'b0, 3'b001, 32'h0000_0103, 32'h0, 0, 32'h0);
    access("f011_ill", 1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 32'h0);
    access("lw_ok", 1'b0, 3'b010, 32'h0000_0400, 32'h0, 0, 32'h1357_9BDF);
    access("lw_timeout", 1'b0, 3'b010, 32'h0000_0400, 32'h0, 100, 32'h0);
    chk("lw_timeout rdata literal", rdata, 32'h0);
    access("lw_race", 1'b0, 3'b010, 32'h0000_0404, 32'h0, 3, 32'hCAFE_F00D);
    chk("lw_race rdata literal", rdata, 32'hCAFE_F00D);
    access("sw_timeout", 1'b1, 3'b010, 32'h0000_0408, 32'h0, 100, 32'h0);
    chk("sw_timeout rdata unchanged", rdata, 32'hCAFE_F00D);

    // Reset asserted in the middle of the second REQ cycle.
    tag = "rst_mid";
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0500; wdata = 32'h0;
    bus.mem_ready = 1'b0;
    e_busy = 1'b1; e_done = 1'b0; e_req = 1'b0;
    exp_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e_busy = 1'b1; e_req = 1'b1; e_we = 1'b0; e_addr = 32'h0000_0500;
    e_be = 4'b1111; e_wd = 32'h0;
    @(posedge clk); #1;
    exp_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid mem_req", bus.mem_req, 0);
    chk("rst_mid busy", busy, 0);
    chk("rst_mid done", done, 0);
    chk("rst_mid rdata", rdata, 0);
    model_rdata = 32'd0;
    @(negedge clk);
    chk("rst_mid done hold", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mid done release", done, 0);
    @(posedge clk); #1;
    access("lw_after_rst", 1'b0, 3'b010, 32'h0000_0600, 32'h0, 1, 32'h0BAD_F00D);
    chk("lw_after_rst rdata literal", rdata, 32'h0BAD_F00D);

    exp_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit sitting directly downstream of the ALU: it takes the ALU result as the effective address and the rs2 value as store data. It runs one RV32I memory access (LB/LH/LW/LBU/LHU/SB/SH/SW) over a simple req/ready data-memory bus. While that access is in progress it stalls the core. It returns a sign- or zero-extended load value, or flags a fault.

## Interface
- TIMEOUT, 255: number of unanswered request cycles before a bus fault is raised. 0 disables the timeout. Range 0..65535.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  core requests an access this cycle. Ignored unless the FSM is in IDLE.
- is_store  in  1  1 = store, 0 = load
- funct3  in  3  000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only)
- addr  in  32  effective address (ALU rvout)
- wdata  in  32  store data (rs2)
- busy  out  1  stall request to the core (combinational)
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done: misaligned address, illegal funct3, or timeout
- rdata  out  32  load result, held until the next completed load
- mem_req  out  1  bus request
- mem_we  out  1  write strobe
- mem_addr  out  32  word address, addr with bits [1:0] forced to 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ready  in  1  slave accepts the request / returns data this cycle
- mem_rdata  in  32  read data, valid when mem_ready=1

## Operation
- States: IDLE, REQ, DONE.
- IDLE + start:
  - Capture is_store, funct3, addr and wdata into registers.
  - Legality check. Illegal if funct3 is 011, 110 or 111, or if is_store=1 with funct3 100 or 101. Misaligned if a halfword access has addr[0]=1, or a word access has addr[1:0]≠0.
  - Illegal or misaligned: go to DONE with fault latched. No bus request is issued.
  - Otherwise: go to REQ and clear the timeout counter.
- REQ:
  - mem_req=1. mem_addr, mem_be, mem_we and mem_wdata are driven from the captured registers and stay stable until mem_ready=1.
  - mem_ready=1: go to DONE, fault=0. For loads, mem_rdata is sampled into rdata.
  - mem_ready=0: counter increments. When TIMEOUT≠0 and the counter reaches TIMEOUT, go to DONE with fault=1.
- DONE: done=1 for exactly one cycle, then IDLE. A start in DONE is ignored.
- Byte enables:
  - B: 1<<addr[1:0]
  - H: 0011 when addr[1]=0, 1100 when addr[1]=1
  - W: 1111
  - Loads use the same masks.
- mem_wdata replication: B replicates wdata[7:0] on all 4 lanes. H replicates wdata[15:0] on both halves. W passes wdata unchanged.
- Load extraction:
  - Select the lane from addr[1:0] (byte) or addr[1] (half).
  - LB and LH sign-extend. LBU and LHU zero-extend. LW passes the word through.
- rdata update rules:
  - Stores never modify rdata.
  - A faulted load sets rdata=0.
- busy = (state==IDLE && start) || state==REQ. It is 0 in DONE, so the core advances in the done cycle.

## Timing
- Reset (asynchronous, immediate): state=IDLE, counter=0. All outputs are 0, including mem_req, mem_we, mem_be, mem_addr, mem_wdata, rdata, done and fault.
- Reset in the middle of REQ drops mem_req immediately. No done pulse is produced.
- Legal access, zero wait states:
  - Cycle 0: start (busy=1).
  - Cycle 1: REQ with mem_req=1 and mem_ready=1.
  - Cycle 2: DONE (done=1, rdata valid).
  - Cycle 3: IDLE.
  - Latency is 2 cycles from start to done; each wait state adds 1.
- Fault at decode: cycle 0 start, cycle 1 done=1 with fault=1, mem_req never asserted.
- Timeout: mem_req stays high for exactly TIMEOUT cycles. done and fault are asserted on the following cycle.
- mem_ready while mem_req=0 is ignored.
- mem_ready arriving on the same cycle the counter reaches TIMEOUT: the ready wins and the access completes with fault=0.
- rdata changes only on the DONE entry edge of a load.

## Test plan
- LW addr=0x100, mem_rdata=0xDEADBEEF, ready on the first REQ cycle:
  - mem_addr=0x100, mem_be=1111, mem_we=0.
  - done 2 cycles after start, rdata=0xDEADBEEF, fault=0.
- LB and LBU addr=0x103, mem_rdata=0x80FF7F01:
  - mem_be=1000.
  - LB gives rdata=0xFFFFFF80. LBU gives rdata=0x00000080.
- SH addr=0x202, wdata=0x1234ABCD, 3 wait states:
  - mem_addr=0x200, mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1.
  - mem_req and bus fields stable for 4 cycles, done 5 cycles after start, rdata unchanged.
- LW addr=0x101; also funct3=100 with is_store=1:
  - done+fault one cycle after start, mem_req never asserted, rdata=0.
- TIMEOUT=4, mem_ready held low:
  - mem_req high for 4 cycles, then done=1 and fault=1.
  - Repeat with ready arriving on the 4th cycle: fault=0.
- rst_n pulled low during the 2nd REQ cycle:
  - mem_req=0 and busy=0 immediately, no done pulse.
  - After release, a new LW completes normally.
